// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Resolves branches, accesses word-wide data memory, registers MEM/WB fields
// and keeps load/store event counters.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned-access suppression
// and sticky error flag); when undefined, MisalignErr_out stays 0.
module mem_stage #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              Branch_in,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic [31:0]       ALUAddResult_in,
  input  logic              Zero_in,
  input  logic [31:0]       ALUResult_in,
  input  logic [31:0]       WriteData_in,
  input  logic [4:0]        WriteReg_in,
  output logic              PCSrc_out,
  output logic [31:0]       BranchTarget_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [31:0]       ReadData_out,
  output logic [31:0]       ALUResult_out,
  output logic [4:0]        WriteReg_out,
  output logic [CNT_W-1:0]  LoadCount_out,
  output logic [CNT_W-1:0]  StoreCount_out,
  output logic              MisalignErr_out
);

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] idx_c;
  logic              misalign_c;
  logic              rd_en_c;
  logic              wr_en_c;
  logic              unused_c;

  logic              regwrite_d, regwrite_q;
  logic              memtoreg_d, memtoreg_q;
  logic [DATA_W-1:0] rdata_d,    rdata_q;
  logic [DATA_W-1:0] alures_d,   alures_q;
  logic [REG_W-1:0]  wreg_d,     wreg_q;
  logic [CNT_W-1:0]  ldcnt_d,    ldcnt_q;
  logic [CNT_W-1:0]  stcnt_d,    stcnt_q;
  logic              mis_d,      mis_q;

  // Word index; upper address bits are dropped so addresses wrap.
  assign idx_c = ALUResult_in[ADDR_W+1:2];

  // Byte-offset bits and the bits above the index do not select a word.
  assign unused_c = ^{ALUResult_in[DATA_W-1:ADDR_W+2], ALUResult_in[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  // A load or store with a non-zero byte offset is suppressed.
  assign misalign_c = (MemRead_in | MemWrite_in) & (ALUResult_in[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  assign rd_en_c = MemRead_in & ~misalign_c;
  assign wr_en_c = MemWrite_in & ~misalign_c & ~Stall_in & ~Rst;

  // Branch resolution is purely combinational and ignores stalls.
  assign PCSrc_out        = Branch_in & Zero_in & ~Rst;
  assign BranchTarget_out = ALUAddResult_in;

  // Data memory write port; contents survive reset.
  always_ff @(posedge Clk) begin
    if (wr_en_c) begin
      mem_q[idx_c] <= WriteData_in;
    end
  end

  // Next-state for the MEM/WB register, counters and sticky error flag.
  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    rdata_d    = rdata_q;
    alures_d   = alures_q;
    wreg_d     = wreg_q;
    ldcnt_d    = ldcnt_q;
    stcnt_d    = stcnt_q;
    mis_d      = mis_q;
    if (Rst) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      rdata_d    = '0;
      alures_d   = '0;
      wreg_d     = '0;
      ldcnt_d    = '0;
      stcnt_d    = '0;
      mis_d      = 1'b0;
    end else if (!Stall_in) begin
      regwrite_d = RegWrite_in;
      memtoreg_d = MemtoReg_in;
      alures_d   = ALUResult_in;
      wreg_d     = WriteReg_in;
      // Read sees the pre-store contents of the same-cycle write.
      rdata_d    = rd_en_c ? mem_q[idx_c] : '0;
      if (rd_en_c) begin
        ldcnt_d = ldcnt_q + CNT_W'(1);
      end
      if (MemWrite_in && !misalign_c) begin
        stcnt_d = stcnt_q + CNT_W'(1);
      end
      mis_d      = mis_q | misalign_c;
    end
  end

  // MEM/WB pipeline register with synchronous reset.
  always_ff @(posedge Clk) begin
    regwrite_q <= regwrite_d;
    memtoreg_q <= memtoreg_d;
    rdata_q    <= rdata_d;
    alures_q   <= alures_d;
    wreg_q     <= wreg_d;
    ldcnt_q    <= ldcnt_d;
    stcnt_q    <= stcnt_d;
    mis_q      <= mis_d;
  end

  assign RegWrite_out    = regwrite_q;
  assign MemtoReg_out    = memtoreg_q;
  assign ReadData_out    = rdata_q;
  assign ALUResult_out   = alures_q;
  assign WriteReg_out    = wreg_q;
  assign LoadCount_out   = ldcnt_q;
  assign StoreCount_out  = stcnt_q;
  assign MisalignErr_out = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven, scoreboard-checked bench for mem_stage.
// Honours MEM_ALIGN_CHECK_EN for the misaligned-access expectations.
module tb_mem_stage;

  localparam int unsigned CNT_W = 4;

  logic              Clk = 1'b0;
  logic              Rst, Stall_in, MemWrite_in, MemRead_in, Branch_in;
  logic              MemtoReg_in, RegWrite_in, Zero_in;
  logic [31:0]       ALUAddResult_in, ALUResult_in, WriteData_in;
  logic [4:0]        WriteReg_in;
  logic              PCSrc_out, RegWrite_out, MemtoReg_out, MisalignErr_out;
  logic [31:0]       BranchTarget_out, ReadData_out, ALUResult_out;
  logic [4:0]        WriteReg_out;
  logic [CNT_W-1:0]  LoadCount_out, StoreCount_out;

  typedef struct packed {
    logic             rw;
    logic             m2r;
    logic [31:0]      rd;
    logic [31:0]      alu;
    logic [4:0]       wreg;
    logic [CNT_W-1:0] lc;
    logic [CNT_W-1:0] sc;
    logic             mis;
  } exp_t;

  typedef struct packed {
    logic        rst, stall, mw, mr, br, zero, m2r, rw;
    logic [31:0] add, alu, wd;
    logic [4:0]  wreg;
    logic        e_pc;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_stage #(.MEM_DEPTH(1024), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Stall_in(Stall_in),
    .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .Branch_in(Branch_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .ALUAddResult_in(ALUAddResult_in), .Zero_in(Zero_in),
    .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .WriteReg_in(WriteReg_in),
    .PCSrc_out(PCSrc_out), .BranchTarget_out(BranchTarget_out),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out), .WriteReg_out(WriteReg_out),
    .LoadCount_out(LoadCount_out), .StoreCount_out(StoreCount_out),
    .MisalignErr_out(MisalignErr_out)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic rst, stall, mw, mr, br, zero, m2r, rw,
                              input logic [31:0] add, alu, wd, input logic [4:0] wreg,
                              input logic e_pc, e_rw, e_m2r, input logic [31:0] e_rd, e_alu,
                              input logic [4:0] e_wreg, input logic [CNT_W-1:0] e_lc, e_sc,
                              input logic e_mis);
    vec_t v;
    v.rst = rst; v.stall = stall; v.mw = mw; v.mr = mr; v.br = br; v.zero = zero;
    v.m2r = m2r; v.rw = rw; v.add = add; v.alu = alu; v.wd = wd; v.wreg = wreg;
    v.e_pc = e_pc;
    v.e.rw = e_rw; v.e.m2r = e_m2r; v.e.rd = e_rd; v.e.alu = e_alu; v.e.wreg = e_wreg;
    v.e.lc = e_lc; v.e.sc = e_sc; v.e.mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check branch outputs, then score MEM/WB.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge Clk);
    Rst = v.rst; Stall_in = v.stall; MemWrite_in = v.mw; MemRead_in = v.mr;
    Branch_in = v.br; Zero_in = v.zero; MemtoReg_in = v.m2r; RegWrite_in = v.rw;
    ALUAddResult_in = v.add; ALUResult_in = v.alu; WriteData_in = v.wd; WriteReg_in = v.wreg;
    sb_q.push_back(v.e);
    #1;
    check("pcsrc", idx, 32'(PCSrc_out), 32'(v.e_pc));
    check("btarget", idx, BranchTarget_out, v.add);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check("regwrite", idx, 32'(RegWrite_out), 32'(e.rw));
    check("memtoreg", idx, 32'(MemtoReg_out), 32'(e.m2r));
    check("readdata", idx, ReadData_out, e.rd);
    check("aluresult", idx, ALUResult_out, e.alu);
    check("writereg", idx, 32'(WriteReg_out), 32'(e.wreg));
    check("loadcnt", idx, 32'(LoadCount_out), 32'(e.lc));
    check("storecnt", idx, 32'(StoreCount_out), 32'(e.sc));
    check("misalign", idx, 32'(MisalignErr_out), 32'(e.mis));
  endtask

  initial begin
    vec_t tbl[18];
    vec_t v;
    logic [CNT_W-1:0] lc, sc;
    logic mis;
    logic [31:0] w16;
    Rst = 1'b1; Stall_in = 0; MemWrite_in = 0; MemRead_in = 0; Branch_in = 0;
    Zero_in = 0; MemtoReg_in = 0; RegWrite_in = 0; ALUAddResult_in = 0;
    ALUResult_in = 0; WriteData_in = 0; WriteReg_in = 0;

    //            rst st mw mr br z m2r rw  add        alu         wd           wreg | pc rw m2r rd           alu         wreg lc sc mis
    tbl[0]  = mk(1, 0, 1, 0, 1, 1, 1, 1, 32'h100, 32'h20,   32'hBAD,      5'd4, 0, 0, 0, 32'h0,        32'h0,      5'd0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h40,   32'hDEADBEEF, 5'd0, 0, 0, 0, 32'h0,        32'h40,     5'd0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0,   32'h40,   32'h0,        5'd5, 0, 1, 1, 32'hDEADBEEF, 32'h40,     5'd5, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 1, 0, 1, 32'h100, 32'h1234, 32'h0,        5'd3, 1, 1, 0, 32'h0,        32'h1234,   5'd3, 1, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 32'h200, 32'h8,    32'h77,       5'd0, 0, 0, 0, 32'h0,        32'h8,      5'd0, 1, 2, 0);
    tbl[5]  = mk(0, 1, 1, 0, 1, 1, 1, 1, 32'h300, 32'h8,    32'h55,       5'd7, 1, 0, 0, 32'h0,        32'h8,      5'd0, 1, 2, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0,   32'h8,    32'h0,        5'd9, 0, 1, 1, 32'h77,       32'h8,      5'd9, 2, 2, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h1000, 32'h11,       5'd0, 0, 0, 0, 32'h0,        32'h1000,   5'd0, 2, 3, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0,   32'h0,    32'h0,        5'd2, 0, 1, 1, 32'h11,       32'h0,      5'd2, 3, 3, 0);
    tbl[9]  = mk(0, 0, 1, 1, 0, 0, 1, 1, 32'h0,   32'h0,    32'h22,       5'd2, 0, 1, 1, 32'h11,       32'h0,      5'd2, 4, 4, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0,   32'h0,    32'h0,        5'd2, 0, 1, 1, 32'h22,       32'h0,      5'd2, 5, 4, 0);
    tbl[11] = mk(0, 1, 1, 1, 0, 0, 0, 0, 32'h0,   32'h0,    32'h66,       5'd1, 0, 1, 1, 32'h22,       32'h0,      5'd2, 5, 4, 0);
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0,   32'h0,    32'h0,        5'd6, 0, 1, 1, 32'h22,       32'h0,      5'd6, 6, 4, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,   32'h20,   32'hA5A5A5A5, 5'd0, 0, 0, 0, 32'h0,        32'h20,     5'd0, 6, 5, 0);
    tbl[14] = mk(1, 0, 1, 1, 1, 1, 0, 1, 32'h0,   32'h20,   32'h99,       5'd8, 0, 0, 0, 32'h0,        32'h0,      5'd0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0,   32'h20,   32'h0,        5'd8, 0, 1, 1, 32'hA5A5A5A5, 32'h20,     5'd8, 1, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0,   32'h40,   32'h0,        5'd8, 0, 1, 1, 32'hDEADBEEF, 32'h40,     5'd8, 2, 0, 0);
    tbl[17] = mk(1, 1, 0, 1, 1, 1, 1, 1, 32'h0,   32'h40,   32'h0,        5'd8, 0, 0, 0, 32'h0,        32'h0,      5'd0, 0, 0, 0);

    for (int i = 0; i < 18; i++) apply(tbl[i], i);

    // Load counter wraps from all-ones back to zero.
    for (int i = 0; i < 16; i++) begin
      v = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 32'h40, 32'h0, 5'd1, 0, 1, 1, 32'hDEADBEEF,
             32'h40, 5'd1, CNT_W'(i + 1), 0, 0);
      apply(v, 100 + i);
    end

    // Misaligned load, aligned load, misaligned store, read-back.
`ifdef MEM_ALIGN_CHECK_EN
    lc = 0; sc = 0; mis = 1'b1; w16 = 32'hDEADBEEF;
    v = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 32'h42, 32'h0, 5'd10, 0, 1, 1, 32'h0, 32'h42, 5'd10, lc, sc, mis);
`else
    lc = 1; sc = 0; mis = 1'b0; w16 = 32'h123;
    v = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 32'h42, 32'h0, 5'd10, 0, 1, 1, 32'hDEADBEEF, 32'h42, 5'd10, lc, sc, mis);
`endif
    apply(v, 200);
    lc = lc + CNT_W'(1);
    v = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 32'h40, 32'h0, 5'd11, 0, 1, 1, 32'hDEADBEEF, 32'h40, 5'd11, lc, sc, mis);
    apply(v, 201);
`ifndef MEM_ALIGN_CHECK_EN
    sc = sc + CNT_W'(1);
`endif
    v = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h41, 32'h123, 5'd12, 0, 1, 0, 32'h0, 32'h41, 5'd12, lc, sc, mis);
    apply(v, 202);
    lc = lc + CNT_W'(1);
    v = mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 32'h40, 32'h0, 5'd13, 0, 1, 1, w16, 32'h40, 5'd13, lc, sc, mis);
    apply(v, 203);
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    apply(v, 204);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, consuming the EX/MEM register outputs. Resolves the branch decision, performs the word-wide data-memory load or store, and registers the write-back fields into the MEM/WB pipeline register for the WB stage. Also keeps load and store event counters for the debug and performance display.

## Interface
Parameters:
- MEM_DEPTH, 1024: data-memory depth in 32-bit words; must be a power of two.
- CNT_W, 16: width of the load and store counters.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Stall_in  input  1  holds the MEM/WB register and counters, and suppresses the memory write.
- MemWrite_in, MemRead_in, Branch_in, MemtoReg_in, RegWrite_in  input  1 each  control fields from EX/MEM.
- ALUAddResult_in  input  32  branch target.
- Zero_in  input  1  ALU zero flag.
- ALUResult_in  input  32  byte address for loads/stores; pass-through value for R-type.
- WriteData_in  input  32  store data (rt value).
- WriteReg_in  input  5  destination register number.
- PCSrc_out  output  1  take-branch select to the IF-stage PC mux.
- BranchTarget_out  output  32  equals ALUAddResult_in.
- RegWrite_out, MemtoReg_out  output  1 each  registered MEM/WB control.
- ReadData_out  output  32  registered load data.
- ALUResult_out  output  32  registered ALU result.
- WriteReg_out  output  5  registered destination register.
- LoadCount_out, StoreCount_out  output  CNT_W  event counters.
- MisalignErr_out  output  1  sticky misaligned-access flag.

## Operation
- Branch resolution is combinational:
  - PCSrc_out = Branch_in & Zero_in & ~Rst.
  - BranchTarget_out = ALUAddResult_in.
- Word index = ALUResult_in[log2(MEM_DEPTH)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
- Store: if MemWrite_in is 1 and Stall_in is 0, mem[index] <= WriteData_in at the clock edge.
- Load: the read is synchronous. ReadData_out <= mem[index] when MemRead_in is 1, otherwise 32'h0.
- MemRead_in and MemWrite_in both 1:
  - the store is performed;
  - ReadData_out receives the pre-store contents (read-before-write);
  - both counters increment.
- MEM/WB register: when Stall_in is 0, RegWrite_out, MemtoReg_out, ALUResult_out and WriteReg_out load their inputs. When Stall_in is 1, all of them and ReadData_out hold.
- Counters:
  - LoadCount_out increments on each non-stalled cycle with MemRead_in = 1.
  - StoreCount_out increments on each non-stalled cycle with MemWrite_in = 1.
  - Both wrap from all-ones to 0.
- Memory contents are not cleared by Rst.

## Timing
- Reset values (the cycle after Rst is sampled high): every registered output = 0, LoadCount_out = 0, StoreCount_out = 0, MisalignErr_out = 0.
- Rst has priority over Stall_in.
- A store is suppressed in any cycle where Rst = 1.
- Latency:
  - MEM/WB outputs are valid 1 cycle after the inputs are sampled.
  - A load in cycle N returns data written by a store in cycle N-1 or earlier.
- PCSrc_out has zero-cycle latency and no dependence on Stall_in.
- A stall asserted mid-sequence freezes state exactly. Releasing it resumes with the inputs present in that cycle.

## Configuration
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - An access (MemRead_in or MemWrite_in) with ALUResult_in[1:0] != 0 is suppressed: no store, ReadData_out <= 32'h0, no counter increment.
  - The access sets MisalignErr_out, which stays at 1 until Rst.
  - RegWrite_out still passes through unchanged.
- Not defined:
  - ALUResult_in[1:0] is ignored and all accesses proceed.
  - MisalignErr_out is tied to 0.

## Test plan
- Store then load: store 32'hDEADBEEF to address 0x40, next cycle load 0x40 → ReadData_out = 32'hDEADBEEF one cycle later; StoreCount_out = 1, LoadCount_out = 1.
- Branch: Branch_in = 1, Zero_in = 1, ALUAddResult_in = 0x100 → same cycle PCSrc_out = 1, BranchTarget_out = 0x100. Zero_in = 0 → PCSrc_out = 0.
- Stall: set Stall_in high with a store of 0x55 to 0x8 and RegWrite_in = 1 pending → outputs hold previous values, mem[2] unchanged, counters unchanged.
- Wrap: with MEM_DEPTH = 1024, store 0x11 at 0x1000, then load 0x0 → 0x11.
- Reset mid-operation: assert Rst during a store to 0x20 → all outputs 0 next cycle, mem[8] unchanged; earlier memory contents still readable after reset.
- Misalignment (macro defined): load from 0x42 → ReadData_out = 0, MisalignErr_out = 1 and held; LoadCount_out unchanged.
